// File: rtl/connect_k_if.sv
// Move handshake and game-status bundle between the game controller (master)
// and connect_k_engine (slave).
interface connect_k_if #(
  parameter int ROWS = 3,
  parameter int COLS = 3
);
  localparam int CELLS  = ROWS * COLS;
  localparam int CELL_W = $clog2(CELLS);

  logic                  new_game;
  logic                  move_valid;
  logic                  move_ready;
  logic [CELL_W-1:0]     move_pos;
  logic [2*CELLS-1:0]    board;
  logic [1:0]            current_player;
  logic [1:0]            winner;
  logic                  draw;
  logic                  move_done;
  logic                  move_illegal;
  logic [CELL_W:0]       move_count;

  modport master (
    output new_game, move_valid, move_pos,
    input  move_ready, board, current_player, winner, draw,
           move_done, move_illegal, move_count
  );

  modport slave (
    input  new_game, move_valid, move_pos,
    output move_ready, board, current_player, winner, draw,
           move_done, move_illegal, move_count
  );
endinterface

// File: rtl/connect_k_engine.sv
// m,n,k game engine: places moves and scans only the lines through the last
// placed cell for a K-run. Define GRAVITY_EN to treat move_pos as a drop column.
//
// state  | meaning
// IDLE   | waiting for a move; ready while the game is still open
// CHECK  | stepping one neighbour per cycle along dir/side from the origin
// FINISH | commit win / draw / player toggle, pulse move_done
module connect_k_engine #(
  parameter int ROWS = 3,
  parameter int COLS = 3,
  parameter int K    = 3
) (
  input  logic      clk_i,
  input  logic      rst_i,
  connect_k_if.slave gi
);
  localparam int CELLS  = ROWS * COLS;
  localparam int CELL_W = $clog2(CELLS);
  localparam int MAXD   = (ROWS > COLS) ? ROWS : COLS;
  localparam int CW     = $clog2(MAXD) + 1;
  localparam int RUN_W  = $clog2(K + 1);
  localparam logic [CELL_W:0]  CELLS_C = (CELL_W + 1)'(CELLS);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(K - 1);

  typedef enum logic [1:0] {IDLE, CHECK, FINISH} state_t;

  state_t                state_q, state_d;
  logic [2*CELLS-1:0]    board_q, board_d;
  logic [1:0]            player_q, player_d;
  logic [1:0]            winner_q, winner_d;
  logic                  draw_q, draw_d;
  logic [CELL_W:0]       count_q, count_d;
  logic                  illegal_q, illegal_d;
  logic [1:0]            dir_q, dir_d;
  logic                  side_q, side_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic                  win_q, win_d;
  logic signed [CW-1:0]  org_r_q, org_r_d, org_c_q, org_c_d;
  logic signed [CW-1:0]  cur_r_q, cur_r_d, cur_c_q, cur_c_d;

  int   mp, tgt_row, tgt_col, dr, dc, nr, nc, nidx;
  logic legal, inb, match, ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      board_q   <= '0;
      player_q  <= 2'd1;
      winner_q  <= 2'd0;
      draw_q    <= 1'b0;
      count_q   <= '0;
      illegal_q <= 1'b0;
      dir_q     <= 2'd0;
      side_q    <= 1'b0;
      run_q     <= '0;
      win_q     <= 1'b0;
      org_r_q   <= '0;
      org_c_q   <= '0;
      cur_r_q   <= '0;
      cur_c_q   <= '0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      player_q  <= player_d;
      winner_q  <= winner_d;
      draw_q    <= draw_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
      dir_q     <= dir_d;
      side_q    <= side_d;
      run_q     <= run_d;
      win_q     <= win_d;
      org_r_q   <= org_r_d;
      org_c_q   <= org_c_d;
      cur_r_q   <= cur_r_d;
      cur_c_q   <= cur_c_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    player_d  = player_q;
    winner_d  = winner_q;
    draw_d    = draw_q;
    count_d   = count_q;
    illegal_d = 1'b0;
    dir_d     = dir_q;
    side_d    = side_q;
    run_d     = run_q;
    win_d     = win_q;
    org_r_d   = org_r_q;
    org_c_d   = org_c_q;
    cur_r_d   = cur_r_q;
    cur_c_d   = cur_c_q;
    tgt_row   = 0;
    tgt_col   = 0;
    legal     = 1'b0;
    dr        = 0;
    dc        = 0;
    nidx      = 0;
    ready     = (state_q == IDLE) && (winner_q == 2'd0) && !draw_q;
    mp        = int'(gi.move_pos);

`ifdef GRAVITY_EN
    // Highest empty row index wins, so the piece lands at the bottom.
    if (mp < COLS) begin
      tgt_col = mp;
      for (int r = 0; r < ROWS; r++) begin
        if (board_q[2*(r*COLS+mp) +: 2] == 2'd0) begin
          tgt_row = r;
          legal   = 1'b1;
        end
      end
    end
`else
    if (mp < CELLS) begin
      tgt_row = mp / COLS;
      tgt_col = mp % COLS;
      legal   = (board_q[2*mp +: 2] == 2'd0);
    end
`endif

    case (dir_q)
      2'd0:    begin dr = 0; dc = 1;  end
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    if (side_q) begin
      dr = -dr;
      dc = -dc;
    end
    nr  = int'(cur_r_q) + dr;
    nc  = int'(cur_c_q) + dc;
    inb = (nr >= 0) && (nr < ROWS) && (nc >= 0) && (nc < COLS);
    if (inb) nidx = nr * COLS + nc;
    match = inb && (board_q[2*nidx +: 2] == player_q);

    case (state_q)
      IDLE: begin
        if (gi.move_valid && ready) begin
          if (!legal) begin
            illegal_d = 1'b1;
          end else begin
            board_d[2*(tgt_row*COLS+tgt_col) +: 2] = player_q;
            count_d = count_q + 1'b1;
            org_r_d = CW'(tgt_row);
            org_c_d = CW'(tgt_col);
            cur_r_d = CW'(tgt_row);
            cur_c_d = CW'(tgt_col);
            dir_d   = 2'd0;
            side_d  = 1'b0;
            run_d   = RUN_W'(1);
            win_d   = 1'b0;
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (match) begin
          run_d   = run_q + 1'b1;
          cur_r_d = CW'(nr);
          cur_c_d = CW'(nc);
          if (run_q == RUN_LAST) begin
            win_d   = 1'b1;
            state_d = FINISH;
          end
        end else if (!side_q) begin
          side_d  = 1'b1;
          cur_r_d = org_r_q;
          cur_c_d = org_c_q;
        end else if (dir_q == 2'd3) begin
          state_d = FINISH;
        end else begin
          dir_d   = dir_q + 2'd1;
          side_d  = 1'b0;
          run_d   = RUN_W'(1);
          cur_r_d = org_r_q;
          cur_c_d = org_c_q;
        end
      end
      FINISH: begin
        if (win_q)                 winner_d = player_q;
        else if (count_q == CELLS_C) draw_d = 1'b1;
        else                       player_d = (player_q == 2'd1) ? 2'd2 : 2'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (gi.new_game) begin
      state_d   = IDLE;
      board_d   = '0;
      player_d  = 2'd1;
      winner_d  = 2'd0;
      draw_d    = 1'b0;
      count_d   = '0;
      illegal_d = 1'b0;
      win_d     = 1'b0;
    end
  end

  assign gi.move_ready     = ready;
  assign gi.board          = board_q;
  assign gi.current_player = player_q;
  assign gi.winner         = winner_q;
  assign gi.draw           = draw_q;
  assign gi.move_count     = count_q;
  assign gi.move_done      = (state_q == FINISH);
  assign gi.move_illegal   = illegal_q;
endmodule
